l2_msg2_out_queue: RTL and testbench
====================================

# l2_msg2_out_queue

Parametrised outbound message buffer for the PMESH L2 model. Collects response messages from NUM_CH internal producers (request-path, writeback-path, ...) into per-channel FIFOs and drives the single msg2 output port through a registered valid/ready stage with round-robin arbitration. It generalises the single-entry msg2 behaviour in three ways: it queues DEPTH messages per channel, it serves multiple producers, and it clears msg2_valid only when a handshake completes and nothing is left to send.

## Interface
- NUM_CH, 2, number of producer channels (1..8)
- DEPTH, 4, entries per channel FIFO (power of two, ≥2)
- TYPE_W, 8, message type width
- SRC_W, 6, destination/source id width
- TAG_W, 26, tag width
- DATA_W, 64, data width
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of all queued and pending messages
- enq_valid  in  NUM_CH  per-channel enqueue request
- enq_ready  out  NUM_CH  per-channel space available
- enq_type  in  NUM_CH*TYPE_W  packed per-channel type
- enq_dest  in  NUM_CH*SRC_W  packed per-channel destination
- enq_tag  in  NUM_CH*TAG_W  packed per-channel tag
- enq_data  in  NUM_CH*DATA_W  packed per-channel data
- msg2_valid  out  1  output message valid
- msg2_ready  in  1  consumer accepts
- msg2_type  out  TYPE_W  output type
- msg2_dest  out  SRC_W  output destination
- msg2_tag  out  TAG_W  output tag
- msg2_data  out  DATA_W  output data
- occupancy  out  NUM_CH*CNT_W  per-channel entry count

## Operation
- Reset (rst_n=0 at a clk edge): all FIFO counts 0, read/write pointers 0, msg2_valid 0, msg2 payload 0, round-robin pointer 0. enq_ready is 0 while rst_n=0.
- Enqueue: channel c writes when enq_valid[c] && enq_ready[c]. enq_ready[c] = (occupancy[c] < DEPTH) && !flush && rst_n. No same-cycle bypass on a full FIFO: a full channel refuses even if it is dequeued that cycle.
- Output register: it is free when !msg2_valid, or when msg2_valid && msg2_ready. When free and at least one FIFO is non-empty, the arbiter picks the winner, pops its head into the register, and msg2_valid is 1 next cycle.
- When free and all FIFOs are empty: msg2_valid goes to 0 and the payload holds its last value.
- Arbitration: round robin. Search starts at the rr pointer. After a grant to channel c, the pointer moves to (c+1) mod NUM_CH. The pointer does not move when there is no grant.
- While msg2_valid && !msg2_ready, the payload and msg2_valid hold stable and no FIFO is popped.
- Flush: acts the same as reset for FIFOs, the output register and the rr pointer. It takes effect at the clk edge where flush=1. Enqueues in that cycle are dropped (enq_ready=0).
- Occupancy counts entries in each FIFO only, excluding the output register. On a simultaneous push and pop of the same channel, occupancy is unchanged.

## Timing
- Latency: an enqueue accepted at edge t, into an empty system, gives msg2_valid=1 after edge t (visible in cycle t+1). This is one cycle, with no combinational path from enq to msg2.
- Throughput: one message per cycle while msg2_ready stays 1 and any FIFO is non-empty.
- msg2_valid falls at the edge where the last handshake completes with all FIFOs empty. It never falls without a handshake, except on reset or flush.
- enq_ready depends only on registered occupancy plus flush and rst_n. It is not combinationally dependent on msg2_ready.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap naturally. full = count==DEPTH, empty = count==0.
- Reset or flush mid-handshake (msg2_valid=1, msg2_ready=1): the message counts as lost and msg2_valid=0 next cycle.

## Structure
- Shared package l2_msg_pkg holds:
  - msg2 type constants (existing data-ack/inv/clear encodings)
  - typedef l2_msg_t {type, dest, tag, data} using the width parameters
- One sub-module, l2_msg_fifo: a single-channel DEPTH-entry FIFO of l2_msg_t with push, pop, full, empty and count ports. It is instantiated NUM_CH times.
- Arbiter and output register are inline in l2_msg2_out_queue.

## Test plan
- Single message: ch0 enqueues type=0x05, tag=0x123, data=0xAB with msg2_ready=1 → msg2_valid=1 with that payload next cycle, then msg2_valid=0 the cycle after.
- Backpressure: msg2_ready=0, ch0 pushes 5 messages (DEPTH=4) → 1 in output register, occupancy[0]=4, enq_ready[0]=0. Payload is stable throughout. Releasing ready drains all 5 in order on 5 consecutive cycles.
- Fairness: both channels hold 3 messages each, msg2_ready=1 → output order ch0,ch1,ch0,ch1,ch0,ch1.
- Clear behaviour: a single handshake with both FIFOs empty → msg2_valid drops the same edge. A held msg2_ready=1 with no traffic keeps msg2_valid=0.
- Flush: both channels partially full and msg2_valid=1, assert flush for 1 cycle → occupancy all 0 and msg2_valid=0 next cycle. An enq_valid during the flush cycle is not stored.
- Reset mid-stream: rst_n=0 during a burst → all outputs return to reset values on the next edge, and traffic resumes normally after rst_n=1.

Source files
------------

// File: rtl/l2_msg_pkg.sv
// Shared definitions for the L2 outbound message path: msg2 type encodings,
// the default field widths and the message record carried through the queues.
package l2_msg_pkg;

  localparam int L2_TYPE_W = 8;
  localparam int L2_SRC_W  = 6;
  localparam int L2_TAG_W  = 26;
  localparam int L2_DATA_W = 64;
  localparam int L2_MSG_W  = L2_TYPE_W + L2_SRC_W + L2_TAG_W + L2_DATA_W;

  localparam logic [L2_TYPE_W-1:0] MSG2_TYPE_INV_FWDACK = 8'd18;
  localparam logic [L2_TYPE_W-1:0] MSG2_TYPE_DATA_ACK   = 8'd20;
  localparam logic [L2_TYPE_W-1:0] MSG2_TYPE_NODATA_ACK = 8'd21;

  // Field order matches the flat {type, dest, tag, data} packing used on the FIFOs.
  typedef struct packed {
    logic [L2_TYPE_W-1:0] mtype;
    logic [L2_SRC_W-1:0]  dest;
    logic [L2_TAG_W-1:0]  tag;
    logic [L2_DATA_W-1:0] data;
  } l2_msg_t;

  function automatic int rr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l2_msg_fifo.sv
// Single-channel message FIFO. When empty, a same-cycle push may be popped
// straight through so a lone message reaches the output register in one cycle.
module l2_msg_fifo #(
  parameter int W     = 104,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && (!empty || do_push);
  assign dout    = empty ? din : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      // Pass-through on an empty FIFO advances both pointers with no count change.
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/l2_msg2_out_queue.sv
// Outbound msg2 buffer: per-producer FIFOs, round-robin arbiter and a
// registered valid/ready output stage that only clears after a handshake.
module l2_msg2_out_queue
  import l2_msg_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4,
  parameter int TYPE_W = 8,
  parameter int SRC_W  = 6,
  parameter int TAG_W  = 26,
  parameter int DATA_W = 64,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [NUM_CH-1:0]          enq_valid,
  output logic [NUM_CH-1:0]          enq_ready,
  input  logic [NUM_CH*TYPE_W-1:0]   enq_type,
  input  logic [NUM_CH*SRC_W-1:0]    enq_dest,
  input  logic [NUM_CH*TAG_W-1:0]    enq_tag,
  input  logic [NUM_CH*DATA_W-1:0]   enq_data,
  output logic                       msg2_valid,
  input  logic                       msg2_ready,
  output logic [TYPE_W-1:0]          msg2_type,
  output logic [SRC_W-1:0]           msg2_dest,
  output logic [TAG_W-1:0]           msg2_tag,
  output logic [DATA_W-1:0]          msg2_data,
  output logic [NUM_CH*CNT_W-1:0]    occupancy
);

  localparam int MSG_W = TYPE_W + SRC_W + TAG_W + DATA_W;
  localparam int RR_W  = rr_w(NUM_CH);

  logic [NUM_CH-1:0] fifo_push;
  logic [NUM_CH-1:0] fifo_pop;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] req;
  logic [MSG_W-1:0]  fifo_din  [NUM_CH];
  logic [MSG_W-1:0]  fifo_head [NUM_CH];

  logic              msg2_valid_reg;
  logic [MSG_W-1:0]  msg2_reg;
  logic [RR_W-1:0]   rr_ptr_reg;
  logic [RR_W-1:0]   rr_ptr_next;
  logic [RR_W-1:0]   grant_idx;
  logic              grant_valid;
  logic              out_free;
  logic              load;

  assign out_free = !msg2_valid_reg || msg2_ready;
  assign load     = out_free && grant_valid;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign fifo_din[gi] = {enq_type[gi*TYPE_W +: TYPE_W],
                             enq_dest[gi*SRC_W  +: SRC_W],
                             enq_tag[gi*TAG_W   +: TAG_W],
                             enq_data[gi*DATA_W +: DATA_W]};

      // Ready looks only at registered occupancy, never at msg2_ready.
      assign enq_ready[gi] = !fifo_full[gi] && !flush && rst_n;
      assign fifo_push[gi] = enq_valid[gi] && enq_ready[gi];
      assign req[gi]       = !fifo_empty[gi] || fifo_push[gi];
      assign fifo_pop[gi]  = load && (grant_idx == RR_W'(gi));

      l2_msg_fifo #(
        .W     (MSG_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
      ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (fifo_push[gi]),
        .din   (fifo_din[gi]),
        .pop   (fifo_pop[gi]),
        .dout  (fifo_head[gi]),
        .full  (fifo_full[gi]),
        .empty (fifo_empty[gi]),
        .count (occupancy[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_valid && req[(int'(rr_ptr_reg) + i) % NUM_CH]) begin
        grant_valid = 1'b1;
        grant_idx   = RR_W'((int'(rr_ptr_reg) + i) % NUM_CH);
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_valid) begin
      rr_ptr_next = (grant_idx == RR_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // A handshake in a reset/flush cycle is dropped: the register simply clears.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      msg2_valid_reg <= 1'b0;
      msg2_reg       <= '0;
      rr_ptr_reg     <= '0;
    end else if (out_free) begin
      if (grant_valid) begin
        msg2_valid_reg <= 1'b1;
        msg2_reg       <= fifo_head[grant_idx];
        rr_ptr_reg     <= rr_ptr_next;
      end else begin
        msg2_valid_reg <= 1'b0;
      end
    end
  end

  assign msg2_valid = msg2_valid_reg;
  assign {msg2_type, msg2_dest, msg2_tag, msg2_data} = msg2_reg;

endmodule

// File: tb/tb_l2_msg2_out_queue.sv
// Self-checking bench for l2_msg2_out_queue: a vector table for single
// messages plus directed sequences, with a scoreboard of expected msg2 output.
module tb_l2_msg2_out_queue;
  import l2_msg_pkg::*;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;
  localparam int TYPE_W = L2_TYPE_W;
  localparam int SRC_W  = L2_SRC_W;
  localparam int TAG_W  = L2_TAG_W;
  localparam int DATA_W = L2_DATA_W;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                     clk;
  logic                     rst_n;
  logic                     flush;
  logic [NUM_CH-1:0]        enq_valid;
  logic [NUM_CH-1:0]        enq_ready;
  logic [NUM_CH*TYPE_W-1:0] enq_type;
  logic [NUM_CH*SRC_W-1:0]  enq_dest;
  logic [NUM_CH*TAG_W-1:0]  enq_tag;
  logic [NUM_CH*DATA_W-1:0] enq_data;
  logic                     msg2_valid;
  logic                     msg2_ready;
  logic [TYPE_W-1:0]        msg2_type;
  logic [SRC_W-1:0]         msg2_dest;
  logic [TAG_W-1:0]         msg2_tag;
  logic [DATA_W-1:0]        msg2_data;
  logic [NUM_CH*CNT_W-1:0]  occupancy;

  l2_msg2_out_queue #(
    .NUM_CH (NUM_CH), .DEPTH (DEPTH), .TYPE_W (TYPE_W), .SRC_W (SRC_W),
    .TAG_W  (TAG_W),  .DATA_W (DATA_W), .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .enq_valid  (enq_valid),
    .enq_ready  (enq_ready),
    .enq_type   (enq_type),
    .enq_dest   (enq_dest),
    .enq_tag    (enq_tag),
    .enq_data   (enq_data),
    .msg2_valid (msg2_valid),
    .msg2_ready (msg2_ready),
    .msg2_type  (msg2_type),
    .msg2_dest  (msg2_dest),
    .msg2_tag   (msg2_tag),
    .msg2_data  (msg2_data),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int      ch;
    l2_msg_t m;
    logic    exp_valid_t1;
    logic    exp_valid_t2;
  } vec_t;

  int      n_vec = 0;
  int      n_err = 0;
  l2_msg_t sb[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic l2_msg_t mk(input logic [TYPE_W-1:0] t, input logic [SRC_W-1:0] d,
                                 input logic [TAG_W-1:0] tg, input logic [DATA_W-1:0] dt);
    l2_msg_t m;
    m.mtype = t;
    m.dest  = d;
    m.tag   = tg;
    m.data  = dt;
    return m;
  endfunction

  function automatic l2_msg_t cur_msg();
    return {msg2_type, msg2_dest, msg2_tag, msg2_data};
  endfunction

  function automatic logic [CNT_W-1:0] occ(input int ch);
    return occupancy[ch*CNT_W +: CNT_W];
  endfunction

  task automatic set_enq(input int ch, input l2_msg_t m);
    enq_valid[ch]                 = 1'b1;
    enq_type[ch*TYPE_W +: TYPE_W] = m.mtype;
    enq_dest[ch*SRC_W +: SRC_W]   = m.dest;
    enq_tag[ch*TAG_W +: TAG_W]    = m.tag;
    enq_data[ch*DATA_W +: DATA_W] = m.data;
  endtask

  task automatic clr_enq();
    enq_valid = '0;
  endtask

  // Scores the handshake that the coming edge completes, then advances one clock.
  task automatic cycle();
    if (rst_n && !flush && msg2_valid && msg2_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: got unexpected msg2 %0h, required no message", cur_msg());
      end else begin
        l2_msg_t e;
        e = sb.pop_front();
        $display("msg2 out: type=%0h dest=%0h tag=%0h data=%0h", msg2_type, msg2_dest, msg2_tag, msg2_data);
        chk("msg2_payload", cur_msg(), e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t    vt[6];
  l2_msg_t bp[5];
  l2_msg_t fa[3];
  l2_msg_t fb[3];
  l2_msg_t extra;

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    enq_valid  = '0;
    enq_type   = '0;
    enq_dest   = '0;
    enq_tag    = '0;
    enq_data   = '0;
    msg2_ready = 1'b0;

    vt[0] = '{ch: 0, m: mk(8'h05, 6'h00, 26'h123, 64'hAB), exp_valid_t1: 1'b1, exp_valid_t2: 1'b0};
    vt[1] = '{ch: 1, m: mk(MSG2_TYPE_DATA_ACK, 6'h3F, 26'h3FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF),
              exp_valid_t1: 1'b1, exp_valid_t2: 1'b0};
    vt[2] = '{ch: 0, m: mk(8'h00, 6'h00, 26'h0, 64'h0), exp_valid_t1: 1'b1, exp_valid_t2: 1'b0};
    vt[3] = '{ch: 1, m: mk(MSG2_TYPE_INV_FWDACK, 6'h02, 26'h1, 64'h0123_4567_89AB_CDEF),
              exp_valid_t1: 1'b1, exp_valid_t2: 1'b0};
    vt[4] = '{ch: 0, m: mk(MSG2_TYPE_NODATA_ACK, 6'h15, 26'h2AA_AAAA, 64'h5555_0000_AAAA_FFFF),
              exp_valid_t1: 1'b1, exp_valid_t2: 1'b0};
    vt[5] = '{ch: 1, m: mk(8'hC3, 6'h2A, 26'h155_5555, 64'hDEAD_BEEF_CAFE_F00D),
              exp_valid_t1: 1'b1, exp_valid_t2: 1'b0};

    for (int i = 0; i < 5; i++) bp[i] = mk(8'h10 + 8'(i), 6'(i), 26'h100 + 26'(i), 64'hB000 + 64'(i));
    for (int i = 0; i < 3; i++) begin
      fa[i] = mk(8'h40 + 8'(i), 6'h0A, 26'h200 + 26'(i), 64'hA0A0_0000 + 64'(i));
      fb[i] = mk(8'h50 + 8'(i), 6'h0B, 26'h300 + 26'(i), 64'hB0B0_0000 + 64'(i));
    end
    extra = mk(8'hEE, 6'h3E, 26'h3EE, 64'hEEEE);

    // Reset state
    cycle();
    cycle();
    chk("rst_valid", msg2_valid, 0);
    chk("rst_payload", cur_msg(), 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_enq_ready", enq_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_enq_ready", enq_ready, 2'b11);
    msg2_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("idle_valid_low", msg2_valid, 0);
    end

    // Single-message vectors: valid one cycle after enqueue, clear after handshake
    for (int i = 0; i < 6; i++) begin
      $display("vec %0d: ch%0d type=%0h tag=%0h data=%0h", i, vt[i].ch, vt[i].m.mtype, vt[i].m.tag, vt[i].m.data);
      set_enq(vt[i].ch, vt[i].m);
      sb.push_back(vt[i].m);
      cycle();
      clr_enq();
      chk("vec_valid_t1", msg2_valid, vt[i].exp_valid_t1);
      chk("vec_occ_t1", occupancy, 0);
      cycle();
      chk("vec_valid_t2", msg2_valid, vt[i].exp_valid_t2);
    end

    // Backpressure: five pushes into DEPTH=4 with the output stalled
    msg2_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_enq(0, bp[i]);
      sb.push_back(bp[i]);
      cycle();
      chk("bp_valid", msg2_valid, 1);
      chk("bp_hold_payload", cur_msg(), bp[0]);
    end
    set_enq(0, extra);
    chk("bp_full_ready0", enq_ready[0], 0);
    chk("bp_ready1", enq_ready[1], 1);
    chk("bp_occ0_full", occ(0), 4);
    cycle();
    chk("bp_occ0_refused", occ(0), 4);
    chk("bp_hold_payload2", cur_msg(), bp[0]);
    msg2_ready = 1'b1;
    #1;
    chk("bp_ready_indep", enq_ready[0], 0);
    cycle();
    chk("bp_no_bypass_full", occ(0), 3);
    clr_enq();
    for (int i = 1; i < 5; i++) begin
      chk("bp_drain_valid", msg2_valid, 1);
      cycle();
    end
    chk("bp_drained_valid", msg2_valid, 0);
    chk("bp_drained_occ", occupancy, 0);

    // Fairness: alternate grants while both channels are backed up
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    msg2_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_enq(0, fa[i]);
      set_enq(1, fb[i]);
      cycle();
    end
    clr_enq();
    for (int i = 0; i < 3; i++) begin
      sb.push_back(fa[i]);
      sb.push_back(fb[i]);
    end
    chk("fair_occ0", occ(0), 2);
    chk("fair_occ1", occ(1), 3);
    chk("fair_head", cur_msg(), fa[0]);
    msg2_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("fair_valid", msg2_valid, 1);
      cycle();
    end
    chk("fair_done_valid", msg2_valid, 0);

    // Flush with both channels loaded and a handshake in flight
    msg2_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_enq(0, fa[i]);
      set_enq(1, fb[i]);
      cycle();
    end
    chk("fl_pre_valid", msg2_valid, 1);
    chk("fl_pre_occ0", occ(0), 1);
    chk("fl_pre_occ1", occ(1), 2);
    flush = 1'b1;
    msg2_ready = 1'b1;
    set_enq(0, extra);
    set_enq(1, extra);
    #1;
    chk("fl_enq_ready", enq_ready, 0);
    cycle();
    sb.delete();
    flush = 1'b0;
    clr_enq();
    chk("fl_occ", occupancy, 0);
    chk("fl_valid", msg2_valid, 0);
    chk("fl_payload", cur_msg(), 0);
    cycle();
    chk("fl_dropped_occ", occupancy, 0);
    chk("fl_dropped_valid", msg2_valid, 0);
    set_enq(0, vt[3].m);
    set_enq(1, vt[4].m);
    sb.push_back(vt[3].m);
    sb.push_back(vt[4].m);
    cycle();
    clr_enq();
    chk("fl_resume_valid", msg2_valid, 1);
    cycle();
    cycle();
    chk("fl_resume_idle", msg2_valid, 0);

    // Reset during a burst
    for (int i = 0; i < 3; i++) begin
      sb.push_back(fa[i]);
      sb.push_back(fb[i]);
    end
    for (int i = 0; i < 3; i++) begin
      set_enq(0, fa[i]);
      set_enq(1, fb[i]);
      cycle();
    end
    chk("burst_valid", msg2_valid, 1);
    rst_n = 1'b0;
    cycle();
    sb.delete();
    chk("mid_rst_valid", msg2_valid, 0);
    chk("mid_rst_payload", cur_msg(), 0);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_enq_ready", enq_ready, 0);
    cycle();
    rst_n = 1'b1;
    clr_enq();
    cycle();
    chk("post_rst_valid", msg2_valid, 0);
    chk("post_rst_occ", occupancy, 0);
    set_enq(0, vt[5].m);
    set_enq(1, vt[1].m);
    sb.push_back(vt[5].m);
    sb.push_back(vt[1].m);
    cycle();
    clr_enq();
    chk("post_rst_resume", msg2_valid, 1);
    cycle();
    cycle();
    chk("post_rst_idle", msg2_valid, 0);

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
